// File: rtl/keypad_scan_ctrl.sv
// Moore control FSM sequencing one keypad press: scan, sync, debounce, re-check, send, await release.
// Outputs are decoded from the state register only, so every enable lags its cause by one clock.
module keypad_scan_ctrl #(
    parameter int SYNC_TIMEOUT   = 16,
    parameter int RELEASE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buttonpush,
    input  logic       synch_done,
    input  logic       debounce_done,
    input  logic       post_debounce,
    output logic       scan_counter_en,
    output logic       WE_synch,
    output logic       debouncer_counter_en,
    output logic       check_again,
    output logic       WE_send,
    output logic       key_event,
    output logic [2:0] state,
    output logic [7:0] abort_cnt
);

    localparam int SW = $clog2(SYNC_TIMEOUT + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_TIMEOUT - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_SCAN    = 3'd0,
        S_SYNC    = 3'd1,
        S_DEB     = 3'd2,
        S_CHECK   = 3'd3,
        S_VERIFY  = 3'd4,
        S_SEND    = 3'd5,
        S_HOLD    = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_abort;
    logic [SW-1:0]   r_sync_cnt;
    logic [RW-1:0]   r_rel_cnt;
    logic [7:0]      r_abort_cnt;

    // Counters are held at zero outside their own state, which gives the clear-on-entry behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_SCAN;
            r_sync_cnt  <= '0;
            r_rel_cnt   <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_SYNC) begin
                r_sync_cnt <= r_sync_cnt + 1'b1;
            end else begin
                r_sync_cnt <= '0;
            end
            if (r_state == S_HOLD && !buttonpush) begin
                r_rel_cnt <= r_rel_cnt + 1'b1;
            end else begin
                r_rel_cnt <= '0;
            end
            if (w_abort && r_abort_cnt != 8'hFF) begin
                r_abort_cnt <= r_abort_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_SCAN: begin
                if (buttonpush) w_next = S_SYNC;
            end
            S_SYNC: begin
                if (synch_done) begin
                    w_next = S_DEB;
                end else if (!buttonpush || r_sync_cnt == SYNC_LAST) begin
                    w_next  = S_SCAN;
                    w_abort = 1'b1;
                end
            end
            S_DEB: begin
                if (debounce_done) w_next = S_CHECK;
            end
            S_CHECK: begin
                w_next = S_VERIFY;
            end
            S_VERIFY: begin
                if (post_debounce) begin
                    w_next = S_SEND;
                end else begin
                    w_next  = S_SCAN;
                    w_abort = 1'b1;
                end
            end
            S_SEND: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                if (!buttonpush && r_rel_cnt == REL_LAST) w_next = S_SCAN;
            end
            S_ILLEGAL: begin
                w_next = S_SCAN;
            end
        endcase
    end

    always_comb begin
        scan_counter_en      = (r_state == S_SCAN);
        WE_synch             = (r_state == S_SYNC);
        debouncer_counter_en = (r_state == S_DEB);
        check_again          = (r_state == S_CHECK) || (r_state == S_VERIFY);
        WE_send              = (r_state == S_SEND);
        key_event            = (r_state == S_SEND);
    end

    assign state     = r_state;
    assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed press scenarios checked against a cycle model every clock.
module tb_keypad_scan_ctrl;

    localparam int ST = 8;
    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       reset, buttonpush, synch_done, debounce_done, post_debounce;
    logic       scan_counter_en, WE_synch, debouncer_counter_en, check_again, WE_send, key_event;
    logic [2:0] state;
    logic [7:0] abort_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SYNC_TIMEOUT(ST), .RELEASE_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .buttonpush(buttonpush), .synch_done(synch_done),
        .debounce_done(debounce_done), .post_debounce(post_debounce),
        .scan_counter_en(scan_counter_en), .WE_synch(WE_synch),
        .debouncer_counter_en(debouncer_counter_en), .check_again(check_again),
        .WE_send(WE_send), .key_event(key_event), .state(state), .abort_cnt(abort_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: current phase of the press, cycles spent in it, run of released cycles, abort tally.
    int m_state, m_dwell, m_low, m_abort;
    bit m_valid = 1'b0;

    always @(posedge clk) begin : model
        int nxt;
        bit ab;
        if (reset) begin
            m_state = 0; m_dwell = 0; m_low = 0; m_abort = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            nxt = m_state;
            ab  = 1'b0;
            case (m_state)
                0: if (buttonpush) nxt = 1;
                1: begin
                    if (synch_done) nxt = 2;
                    else if (!buttonpush || m_dwell + 1 >= ST) begin nxt = 0; ab = 1'b1; end
                end
                2: if (debounce_done) nxt = 3;
                3: nxt = 4;
                4: begin
                    if (post_debounce) nxt = 5;
                    else begin nxt = 0; ab = 1'b1; end
                end
                5: nxt = 6;
                6: begin
                    if (buttonpush) m_low = 0;
                    else m_low++;
                    if (m_low == RC) nxt = 0;
                end
                default: nxt = 0;
            endcase
            if (ab && m_abort < 255) m_abort++;
            if (nxt != m_state) begin m_dwell = 0; m_low = 0; end
            else m_dwell++;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_state",     32'(state),                m_state);
            check("model_scan_en",   32'(scan_counter_en),      32'(m_state == 0));
            check("model_we_synch",  32'(WE_synch),             32'(m_state == 1));
            check("model_deb_en",    32'(debouncer_counter_en), 32'(m_state == 2));
            check("model_chk_again", 32'(check_again),          32'(m_state == 3 || m_state == 4));
            check("model_we_send",   32'(WE_send),              32'(m_state == 5));
            check("model_key_event", 32'(key_event),            32'(m_state == 5));
            check("model_abort_cnt", 32'(abort_cnt),            m_abort);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int sends, kes, n;
    int pat [6] = '{0, 0, 1, 0, 0, 0};

    initial begin
        reset = 1'b1; buttonpush = 1'b0; synch_done = 1'b0;
        debounce_done = 1'b0; post_debounce = 1'b0;
        tick(3);
        check("t1_reset_state", 32'(state), 0);
        check("t1_reset_scan", 32'(scan_counter_en), 1);
        check("t1_reset_abort", 32'(abort_cnt), 0);
        reset = 1'b0;
        tick(20);
        check("t1_idle_state", 32'(state), 0);
        check("t1_idle_send", 32'(WE_send), 0);

        // Accepted press
        buttonpush = 1'b1;
        tick(1);
        check("t2_sync", 32'(state), 1);
        tick(1);
        synch_done = 1'b1;
        tick(1);
        check("t2_deb", 32'(state), 2);
        synch_done = 1'b0;
        tick(9);
        check("t2_deb_wait", 32'(state), 2);
        debounce_done = 1'b1; post_debounce = 1'b1;
        tick(1);
        check("t2_check", 32'(state), 3);
        debounce_done = 1'b0;
        sends = 0; kes = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            sends += int'(WE_send);
            kes   += int'(key_event);
        end
        check("t2_send_pulses", sends, 1);
        check("t2_key_events", kes, 1);
        check("t2_hold", 32'(state), 6);

        // Release filter with a glitch
        post_debounce = 1'b0;
        for (int i = 0; i < 6; i++) begin
            buttonpush = pat[i][0];
            tick(1);
            check("t3_still_hold", 32'(state), 6);
        end
        buttonpush = 1'b0;
        tick(1);
        check("t3_released", 32'(state), 0);

        // Bounce reject
        sends = 0;
        buttonpush = 1'b1;
        tick(1); sends += int'(WE_send);
        synch_done = 1'b1;
        tick(1); sends += int'(WE_send);
        synch_done = 1'b0; debounce_done = 1'b1;
        tick(1); sends += int'(WE_send);
        debounce_done = 1'b0; buttonpush = 1'b0; post_debounce = 1'b0;
        tick(1); sends += int'(WE_send);
        check("t4_verify", 32'(state), 4);
        tick(1); sends += int'(WE_send);
        check("t4_state", 32'(state), 0);
        check("t4_abort", 32'(abort_cnt), 1);
        check("t4_no_send", sends, 0);

        // Sync timeout
        buttonpush = 1'b1;
        tick(1);
        n = 0;
        while (state == 3'd1 && n < 20) begin
            n++;
            tick(1);
        end
        check("t5_sync_dwell", n, 8);
        check("t5_state", 32'(state), 0);
        check("t5_abort", 32'(abort_cnt), 2);
        buttonpush = 1'b0;
        tick(2);

        // Reset in the middle of debounce
        buttonpush = 1'b1;
        tick(1);
        synch_done = 1'b1;
        tick(1);
        synch_done = 1'b0;
        tick(3);
        check("t6_pre_state", 32'(state), 2);
        check("t6_pre_abort", 32'(abort_cnt), 2);
        reset = 1'b1;
        tick(1);
        check("t6_state", 32'(state), 0);
        check("t6_abort", 32'(abort_cnt), 0);
        check("t6_deb_en", 32'(debouncer_counter_en), 0);
        check("t6_scan_en", 32'(scan_counter_en), 1);
        reset = 1'b0; buttonpush = 1'b0;
        tick(5);
        check("t6_idle", 32'(state), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
